// File: rtl/mii_led_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mii_led_tx_pkg
// Description : Shared MII nibble constants, CRC-32 constants and transmit
//               state encoding for the LED-command MII transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package mii_led_tx_pkg;

    // MII line constants: preamble nibble and the nibble that completes the SFD
    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hd;

    // Reflected CRC-32 (IEEE 802.3)
    localparam logic [31:0] CRC32_POLY_REFL = 32'hedb88320;
    localparam logic [31:0] CRC32_INIT      = 32'hffffffff;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hdebb20e3;

    // Fixed frame section lengths in nibbles
    localparam int PREAMBLE_NIBBLES = 15;
    localparam int HEADER_NIBBLES   = 28;
    localparam int FCS_NIBBLES      = 8;

    // Transmit state encoding
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_HEADER   = 3'd3,
        ST_PAYLOAD  = 3'd4,
        ST_FCS      = 3'd5,
        ST_IFG      = 3'd6
    } tx_state_t;

    // Larger of two integers, used to size the shared nibble counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mii_led_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : mii_led_tx_if
// Description : Request handshake and MII transmit pins of the LED-command
//               transmitter. master = board logic side, slave = transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mii_led_tx_if;
    logic       start;
    logic [3:0] value;
    logic       busy;
    logic       eth_tx_en;
    logic [3:0] eth_txd;

    modport master (
        output start,
        output value,
        input  busy,
        input  eth_tx_en,
        input  eth_txd
    );

    modport slave (
        input  start,
        input  value,
        output busy,
        output eth_tx_en,
        output eth_txd
    );
endinterface
`default_nettype wire

// File: rtl/mii_led_tx_crc32.sv
`default_nettype none
// ============================================================================
// Module      : crc32_nibble
// Description : Combinational reflected CRC-32 update over one MII nibble.
//               Bit 0 of the nibble is the first bit on the wire. Shared with
//               the receive path for FCS checking.
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_nibble
    import mii_led_tx_pkg::*;
(
    input  wire logic [31:0] i_crc,
    input  wire logic [3:0]  i_data,
    output logic      [31:0] o_crc
);

    logic [31:0] w_crc;

    // Four LSB-first shift steps of the reflected polynomial division
    always_comb begin
        w_crc = i_crc;
        for (int i = 0; i < 4; i++) begin
            if (w_crc[0] ^ i_data[i]) begin
                w_crc = (w_crc >> 1) ^ CRC32_POLY_REFL;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
        o_crc = w_crc;
    end

endmodule
`default_nettype wire

// File: rtl/mii_led_tx.sv
`default_nettype none
// ============================================================================
// Module      : mii_led_tx
// Description : MII 4-bit frame transmitter. A start pulse sends one minimum
//               Ethernet frame whose first payload byte carries a 4-bit value,
//               followed by an enforced inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
module mii_led_tx
    import mii_led_tx_pkg::*;
#(
    parameter logic [47:0] DST_MAC     = 48'h123456789abc,
    parameter logic [47:0] SRC_MAC     = 48'h02000000beef,
    parameter logic [15:0] ETHERTYPE   = 16'h88b5,
    parameter int          PAYLOAD_LEN = 46,
    parameter int          IFG_NIBBLES = 24
) (
    input  wire logic  eth_tx_clk,
    input  wire logic  resetn,
    mii_led_tx_if.slave tx
);

    // Byte-reverse the header so byte k of the wire order sits at bits [8k+7:8k]
    function automatic logic [111:0] swap_bytes(input logic [111:0] x);
        logic [111:0] y;
        y = '0;
        for (int k = 0; k < 14; k++) begin
            y[8*k +: 8] = x[111 - 8*k -: 8];
        end
        return y;
    endfunction

    localparam int c_payload_nibbles = 2 * PAYLOAD_LEN;
    localparam int c_max_terminal    = max_int(max_int(max_int(PREAMBLE_NIBBLES, HEADER_NIBBLES),
                                                       max_int(c_payload_nibbles, FCS_NIBBLES)),
                                               IFG_NIBBLES);
    localparam int c_cnt_w           = $clog2(c_max_terminal);

    localparam logic [c_cnt_w-1:0] c_last_preamble = c_cnt_w'(PREAMBLE_NIBBLES - 1);
    localparam logic [c_cnt_w-1:0] c_last_header   = c_cnt_w'(HEADER_NIBBLES - 1);
    localparam logic [c_cnt_w-1:0] c_last_payload  = c_cnt_w'(c_payload_nibbles - 1);
    localparam logic [c_cnt_w-1:0] c_last_fcs      = c_cnt_w'(FCS_NIBBLES - 1);
    localparam logic [c_cnt_w-1:0] c_last_ifg      = c_cnt_w'(IFG_NIBBLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one       = c_cnt_w'(1);

    localparam logic [111:0] c_header_wire = swap_bytes({DST_MAC, SRC_MAC, ETHERTYPE});

    tx_state_t            r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [3:0]           r_value;
    logic [31:0]          r_crc;
    logic                 r_busy;
    logic                 r_tx_en;
    logic [3:0]           r_txd;

    logic [c_cnt_w-2:0]   w_byte_idx;
    logic [7:0]           w_hdr_byte;
    logic [7:0]           w_pay_byte;
    logic [7:0]           w_cur_byte;
    logic [3:0]           w_data_nib;
    logic [3:0]           w_fcs_nib;
    logic [31:0]          w_crc_next;

    // Byte mux for header/payload: two nibbles per byte, low nibble first
    always_comb begin
        w_byte_idx = r_cnt[c_cnt_w-1:1];
        w_hdr_byte = 8'(c_header_wire >> {w_byte_idx, 3'b000});
        w_pay_byte = (w_byte_idx == '0) ? {4'h0, r_value} : 8'h00;
        w_cur_byte = (r_state == ST_HEADER) ? w_hdr_byte : w_pay_byte;
        w_data_nib = r_cnt[0] ? w_cur_byte[7:4] : w_cur_byte[3:0];
        w_fcs_nib  = 4'(~r_crc >> {r_cnt[2:0], 2'b00});
    end

    crc32_nibble u_crc (
        .i_crc  (r_crc),
        .i_data (w_data_nib),
        .o_crc  (w_crc_next)
    );

    // Frame sequencer: each edge registers the nibble for the current count and advances
    always_ff @(posedge eth_tx_clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_value <= 4'h0;
            r_crc   <= CRC32_INIT;
            r_busy  <= 1'b0;
            r_tx_en <= 1'b0;
            r_txd   <= 4'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx_en <= 1'b0;
                    r_txd   <= 4'h0;
                    r_cnt   <= '0;
                    if (tx.start && !r_busy) begin
                        r_value <= tx.value;
                        r_busy  <= 1'b1;
                        r_state <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    r_tx_en <= 1'b1;
                    r_txd   <= PREAMBLE_NIB;
                    if (r_cnt == c_last_preamble) begin
                        r_cnt   <= '0;
                        r_state <= ST_SFD;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                ST_SFD: begin
                    r_tx_en <= 1'b1;
                    r_txd   <= SFD_NIB;
                    r_crc   <= CRC32_INIT;
                    r_cnt   <= '0;
                    r_state <= ST_HEADER;
                end
                ST_HEADER: begin
                    r_tx_en <= 1'b1;
                    r_txd   <= w_data_nib;
                    r_crc   <= w_crc_next;
                    if (r_cnt == c_last_header) begin
                        r_cnt   <= '0;
                        r_state <= ST_PAYLOAD;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                ST_PAYLOAD: begin
                    r_tx_en <= 1'b1;
                    r_txd   <= w_data_nib;
                    r_crc   <= w_crc_next;
                    if (r_cnt == c_last_payload) begin
                        r_cnt   <= '0;
                        r_state <= ST_FCS;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                ST_FCS: begin
                    // CRC register holds still here; the FCS is read from it
                    r_tx_en <= 1'b1;
                    r_txd   <= w_fcs_nib;
                    if (r_cnt == c_last_fcs) begin
                        r_cnt   <= '0;
                        r_state <= ST_IFG;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                ST_IFG: begin
                    r_tx_en <= 1'b0;
                    r_txd   <= 4'h0;
                    if (r_cnt == c_last_ifg) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_tx_en <= 1'b0;
                    r_txd   <= 4'h0;
                end
            endcase
        end
    end

    assign tx.busy      = r_busy;
    assign tx.eth_tx_en = r_tx_en;
    assign tx.eth_txd   = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_mii_led_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mii_led_tx
// Description : Self-checking bench for mii_led_tx with a byte-level frame
//               model, a software CRC-32 and a simple receiver model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mii_led_tx;

    localparam logic [47:0] DST_MAC   = 48'h123456789abc;
    localparam logic [47:0] SRC_MAC   = 48'h02000000beef;
    localparam logic [15:0] ETHERTYPE = 16'h88b5;
    localparam int          PAY_LEN   = 46;
    localparam int          IFG       = 24;
    localparam int          TX_LEN    = 16 + 28 + 2*PAY_LEN + 8;
    localparam int          PERIOD    = 1 + TX_LEN + IFG;

    logic eth_tx_clk = 1'b0;
    logic resetn     = 1'b0;
    int   cyc        = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;

    logic [3:0] cap[$];
    logic [3:0] exp_nibs[$];
    int         cap_start;
    int         cap_end;

    mii_led_tx_if tx_if ();

    mii_led_tx #(
        .DST_MAC     (DST_MAC),
        .SRC_MAC     (SRC_MAC),
        .ETHERTYPE   (ETHERTYPE),
        .PAYLOAD_LEN (PAY_LEN),
        .IFG_NIBBLES (IFG)
    ) dut (
        .eth_tx_clk (eth_tx_clk),
        .resetn     (resetn),
        .tx         (tx_if)
    );

    always #20 eth_tx_clk = ~eth_tx_clk;
    always @(posedge eth_tx_clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no end, need end");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge eth_tx_clk);
        #1;
    endtask

    function automatic logic [31:0] sw_crc(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
        return r;
    endfunction

    // Expected wire nibbles for a frame carrying value v
    function automatic void build_expected(input logic [3:0] v);
        logic [7:0]  bq[$];
        logic [31:0] c;
        logic [31:0] fcs;
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] e;
        d = DST_MAC; s = SRC_MAC; e = ETHERTYPE;
        for (int j = 0; j < 6; j++) bq.push_back(d[47-8*j -: 8]);
        for (int j = 0; j < 6; j++) bq.push_back(s[47-8*j -: 8]);
        bq.push_back(e[15:8]);
        bq.push_back(e[7:0]);
        bq.push_back({4'h0, v});
        for (int j = 1; j < PAY_LEN; j++) bq.push_back(8'h00);
        c = 32'hffffffff;
        foreach (bq[j]) c = sw_crc(c, bq[j]);
        fcs = ~c;
        for (int j = 0; j < 4; j++) bq.push_back(fcs[8*j +: 8]);
        exp_nibs.delete();
        for (int j = 0; j < 15; j++) exp_nibs.push_back(4'h5);
        exp_nibs.push_back(4'hd);
        foreach (bq[j]) begin
            exp_nibs.push_back(bq[j][3:0]);
            exp_nibs.push_back(bq[j][7:4]);
        end
    endfunction

    // Receiver model: preamble/SFD, destination filter, FCS residue, LED nibble
    function automatic void rx_model(output bit good, output logic [3:0] led);
        logic [7:0]  bytes[$];
        logic [31:0] c;
        logic [47:0] d;
        good = 1'b1;
        led  = 4'h0;
        d    = DST_MAC;
        if (cap.size() < 16 + 2*19 || (cap.size() % 2) != 0) begin
            good = 1'b0;
            return;
        end
        for (int i = 0; i < 15; i++) if (cap[i] !== 4'h5) good = 1'b0;
        if (cap[15] !== 4'hd) good = 1'b0;
        for (int i = 16; i < cap.size(); i += 2) bytes.push_back({cap[i+1], cap[i]});
        for (int j = 0; j < 6; j++) if (bytes[j] !== d[47-8*j -: 8]) good = 1'b0;
        c = 32'hffffffff;
        foreach (bytes[j]) c = sw_crc(c, bytes[j]);
        if (c !== 32'hdebb20e3) good = 1'b0;
        led = bytes[14][3:0];
    endfunction

    // Waits (bounded) for tx_en, then records nibbles until tx_en drops
    task automatic capture_frame(output bit ok);
        int n;
        ok = 1'b0;
        cap.delete();
        n = 0;
        while (tx_if.eth_tx_en !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        if (tx_if.eth_tx_en !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL frame_start: tx_en got %b, need 1 within 60 cycles", tx_if.eth_tx_en);
            return;
        end
        cap_start = cyc;
        n = 0;
        while (tx_if.eth_tx_en === 1'b1 && n < 400) begin
            cap.push_back(tx_if.eth_txd);
            tick();
            n++;
        end
        cap_end = cyc;
        ok = 1'b1;
    endtask

    task automatic check_frame(input string tag, input logic [3:0] v);
        int         mism;
        int         first;
        logic [3:0] led;
        bit         good;
        build_expected(v);
        n_checks++;
        if (cap.size() !== TX_LEN) begin
            n_fail++;
            $display("FAIL %s length: got %0d tx_en cycles, need %0d", tag, cap.size(), TX_LEN);
        end
        mism = 0; first = -1;
        for (int i = 0; i < exp_nibs.size(); i++) begin
            if (i >= cap.size() || cap[i] !== exp_nibs[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL %s nibbles: %0d wrong, first at %0d got %h need %h", tag, mism, first,
                     (first < cap.size()) ? cap[first] : 4'hx, exp_nibs[first]);
        end
        rx_model(good, led);
        n_checks++;
        if (good !== 1'b1) begin
            n_fail++;
            $display("FAIL %s rx_crc: receiver got frame good=%b, need 1", tag, good);
        end
        n_checks++;
        if (led !== v) begin
            n_fail++;
            $display("FAIL %s rx_led: got %h, need %h", tag, led, v);
        end
    endtask

    task automatic wait_not_busy();
        int n;
        n = 0;
        while (tx_if.busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (tx_if.busy !== 1'b0) begin
            n_checks++; n_fail++;
            $display("FAIL busy_release: busy got %b, need 0 within 100 cycles", tx_if.busy);
        end
    endtask

    task automatic test_reset();
        tx_if.start = 1'b0;
        tx_if.value = 4'h0;
        resetn = 1'b0;
        tick(); tick();
        n_checks++;
        if ({tx_if.busy, tx_if.eth_tx_en, tx_if.eth_txd} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b tx_en=%b txd=%h, need 0 0 0",
                     tx_if.busy, tx_if.eth_tx_en, tx_if.eth_txd);
        end
        resetn = 1'b1;
        tick(); tick();
        n_checks++;
        if ({tx_if.busy, tx_if.eth_tx_en, tx_if.eth_txd} !== 6'b0) begin
            n_fail++;
            $display("FAIL idle_outputs: got busy=%b tx_en=%b txd=%h, need 0 0 0",
                     tx_if.busy, tx_if.eth_tx_en, tx_if.eth_txd);
        end
    endtask

    task automatic test_single_frame(input string tag, input logic [3:0] v);
        int acc;
        bit ok;
        tx_if.start = 1'b1;
        tx_if.value = v;
        tick();
        acc = cyc;
        tx_if.start = 1'b0;
        tx_if.value = ~v;
        n_checks++;
        if (tx_if.busy !== 1'b1 || tx_if.eth_tx_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: got busy=%b tx_en=%b, need busy=1 tx_en=0",
                     tag, tx_if.busy, tx_if.eth_tx_en);
        end
        capture_frame(ok);
        if (!ok) return;
        n_checks++;
        if (cap_start !== acc + 1) begin
            n_fail++;
            $display("FAIL %s latency: tx_en rose %0d cycles after accept, need 1", tag, cap_start - acc);
        end
        check_frame(tag, v);
        wait_not_busy();
        n_checks++;
        if (cyc !== cap_end + IFG - 1) begin
            n_fail++;
            $display("FAIL %s busy_fall: busy fell %0d cycles after last tx_en, need %0d",
                     tag, cyc - cap_end + 1, IFG);
        end
    endtask

    task automatic test_ignore_start();
        int         rises;
        int         rise_k;
        logic       prev;
        logic [3:0] v0;
        rises = 0; rise_k = -1; prev = 1'b0; v0 = 4'h0;
        cap.delete();
        for (int k = 0; k < 300; k++) begin
            tx_if.start = (k == 10 || k == 50 || k == 150);
            tx_if.value = 4'($urandom);
            if (k == 10) v0 = tx_if.value;
            tick();
            if (tx_if.eth_tx_en === 1'b1 && !prev) begin
                rises++;
                if (rise_k < 0) rise_k = k;
            end
            if (tx_if.eth_tx_en === 1'b1) cap.push_back(tx_if.eth_txd);
            prev = tx_if.eth_tx_en;
        end
        tx_if.start = 1'b0;
        n_checks++;
        if (rises !== 1) begin
            n_fail++;
            $display("FAIL ignore_start count: got %0d frames, need 1", rises);
        end
        n_checks++;
        if (rise_k !== 11) begin
            n_fail++;
            $display("FAIL ignore_start latency: tx_en rose at step %0d, need 11", rise_k);
        end
        check_frame("ignore_start", v0);
    endtask

    task automatic test_reset_mid();
        int         n;
        bit         ok;
        logic [3:0] v;
        v = 4'($urandom);
        tx_if.start = 1'b1;
        tx_if.value = v;
        tick();
        tx_if.start = 1'b0;
        n = 0;
        for (int k = 0; k < 100 && n < 60; k++) begin
            tick();
            if (tx_if.eth_tx_en === 1'b1) n++;
        end
        #10;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({tx_if.busy, tx_if.eth_tx_en, tx_if.eth_txd} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_reset async: got busy=%b tx_en=%b txd=%h, need 0 0 0",
                     tx_if.busy, tx_if.eth_tx_en, tx_if.eth_txd);
        end
        tick(); tick();
        resetn = 1'b1;
        tick();
        n_checks++;
        if ({tx_if.busy, tx_if.eth_tx_en} !== 2'b0) begin
            n_fail++;
            $display("FAIL mid_reset release: got busy=%b tx_en=%b, need 0 0", tx_if.busy, tx_if.eth_tx_en);
        end
        v = 4'($urandom);
        tx_if.start = 1'b1;
        tx_if.value = v;
        tick();
        tx_if.start = 1'b0;
        n_checks++;
        if (tx_if.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset no_ifg: busy got %b, need 1 right after release", tx_if.busy);
        end
        capture_frame(ok);
        if (ok) check_frame("after_reset", v);
        wait_not_busy();
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals[0:539];
        int         rise_at[$];
        int         fall_at[$];
        logic       prev;
        prev = 1'b0;
        cap.delete();
        for (int k = 0; k < 540; k++) begin
            tx_if.start = (k < 500);
            tx_if.value = 4'($urandom);
            vals[k] = tx_if.value;
            tick();
            if (tx_if.eth_tx_en === 1'b1 && !prev) begin
                rise_at.push_back(k);
                cap.delete();
            end
            if (tx_if.eth_tx_en === 1'b1) cap.push_back(tx_if.eth_txd);
            if (tx_if.eth_tx_en !== 1'b1 && prev) begin
                fall_at.push_back(k);
                check_frame($sformatf("b2b_%0d", fall_at.size() - 1), vals[PERIOD * (fall_at.size() - 1)]);
            end
            prev = tx_if.eth_tx_en;
        end
        tx_if.start = 1'b0;
        n_checks++;
        if (rise_at.size() !== 3) begin
            n_fail++;
            $display("FAIL b2b count: got %0d frames, need 3", rise_at.size());
        end
        for (int j = 0; j < 3 && j < rise_at.size(); j++) begin
            n_checks++;
            if (rise_at[j] !== 1 + PERIOD * j) begin
                n_fail++;
                $display("FAIL b2b start_%0d: tx_en rose at step %0d, need %0d", j, rise_at[j], 1 + PERIOD * j);
            end
        end
        for (int j = 1; j < rise_at.size() && j <= fall_at.size(); j++) begin
            n_checks++;
            if (rise_at[j] - fall_at[j-1] !== IFG + 1) begin
                n_fail++;
                $display("FAIL b2b gap_%0d: idle %0d cycles, need %0d", j, rise_at[j] - fall_at[j-1], IFG + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame("frame_a", 4'ha);
        test_single_frame("frame_5", 4'h5);
        for (int i = 0; i < 3; i++) test_single_frame($sformatf("frame_rand%0d", i), 4'($urandom));
        test_ignore_start();
        wait_not_busy();
        test_reset_mid();
        test_back_to_back();
        wait_not_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
